// File: rtl/uart_tx_arbiter_if.sv
// Bundle of requester and transmitter signals around the shared UART TX arbiter.
// The slave modport is the arbiter's view; master is the environment's view.
interface uart_tx_arbiter_if #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8
) ();
    localparam int IW = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]            req;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]            req_par_en;
    logic [NUM_REQ-1:0]            ack;
    logic [NUM_REQ-1:0]            err;
    logic [DATA_WIDTH-1:0]         tx_p_data;
    logic                          tx_par_en;
    logic                          tx_data_valid;
    logic                          tx_busy;
    logic [IW-1:0]                 grant_id;
    logic                          arb_busy;

    modport slave (
        input  req, req_data, req_par_en, tx_busy,
        output ack, err, tx_p_data, tx_par_en, tx_data_valid, grant_id, arb_busy
    );

    modport master (
        output req, req_data, req_par_en, tx_busy,
        input  ack, err, tx_p_data, tx_par_en, tx_data_valid, grant_id, arb_busy
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NUM_REQ byte requesters,
// with frame tracking via tx_busy, an inter-frame gap and a start watchdog.
module uart_tx_arbiter #(
    parameter int NUM_REQ       = 4,
    parameter int DATA_WIDTH    = 8,
    parameter int GAP_CYCLES    = 2,
    parameter int START_TIMEOUT = 16
) (
    input  logic                clk,
    input  logic                rst,
    uart_tx_arbiter_if.slave    bus
);
    localparam int IW = $clog2(NUM_REQ);
    localparam int TW = $clog2(START_TIMEOUT);
    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [TW-1:0] TIMER_LAST = TW'(START_TIMEOUT - 1);
    localparam logic [GW-1:0] GAP_LAST   = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    typedef enum logic [2:0] {
        IDLE,
        LAUNCH,
        WAIT_BUSY,
        TRANSMIT,
        GAP
    } state_t;

    state_t                 state_reg, state_next;
    logic [IW-1:0]          ptr_reg, ptr_next;
    logic [TW-1:0]          timer_reg, timer_next;
    logic [GW-1:0]          gap_cnt_reg, gap_cnt_next;
    logic [DATA_WIDTH-1:0]  tx_p_data_reg, tx_p_data_next;
    logic                   tx_par_en_reg, tx_par_en_next;
    logic                   tx_data_valid_reg, tx_data_valid_next;
    logic [IW-1:0]          grant_id_reg, grant_id_next;
    logic                   arb_busy_reg, arb_busy_next;
    logic [NUM_REQ-1:0]     ack_reg, ack_next;
    logic [NUM_REQ-1:0]     err_reg, err_next;

    logic [DATA_WIDTH-1:0]  req_byte [NUM_REQ];
    logic                   pick_valid;
    logic [IW-1:0]          pick_id;
    logic [IW-1:0]          cand;

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign req_byte[gi] = bus.req_data[gi*DATA_WIDTH +: DATA_WIDTH];
        end
    endgenerate

    // Walk candidates from farthest to nearest so the nearest set bit after ptr wins.
    always_comb begin
        pick_valid = 1'b0;
        pick_id    = '0;
        cand       = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            cand = IW'((int'(ptr_reg) + k) % NUM_REQ);
            if (bus.req[cand]) begin
                pick_valid = 1'b1;
                pick_id    = cand;
            end
        end
    end

    always_comb begin
        state_next         = state_reg;
        ptr_next           = ptr_reg;
        timer_next         = timer_reg;
        gap_cnt_next       = gap_cnt_reg;
        tx_p_data_next     = tx_p_data_reg;
        tx_par_en_next     = tx_par_en_reg;
        grant_id_next      = grant_id_reg;
        tx_data_valid_next = 1'b0;
        ack_next           = '0;
        err_next           = '0;

        unique case (state_reg)
            IDLE: begin
                if (pick_valid && !bus.tx_busy) begin
                    tx_p_data_next     = req_byte[pick_id];
                    tx_par_en_next     = bus.req_par_en[pick_id];
                    grant_id_next      = pick_id;
                    ptr_next           = pick_id;
                    tx_data_valid_next = 1'b1;
                    state_next         = LAUNCH;
                end
            end
            LAUNCH: begin
                timer_next = '0;
                state_next = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (bus.tx_busy) begin
                    ack_next[grant_id_reg] = 1'b1;
                    state_next             = TRANSMIT;
                end else begin
                    timer_next = timer_reg + 1'b1;
                    if (timer_next == TIMER_LAST) begin
                        err_next[grant_id_reg] = 1'b1;
                        gap_cnt_next           = '0;
                        state_next             = GAP;
                    end
                end
            end
            TRANSMIT: begin
                if (!bus.tx_busy) begin
                    gap_cnt_next = '0;
                    state_next   = (GAP_CYCLES == 0) ? IDLE : GAP;
                end
            end
            GAP: begin
                // A timeout with no configured gap still spends one cycle here.
                if (GAP_CYCLES == 0 || gap_cnt_reg == GAP_LAST) begin
                    state_next = IDLE;
                end else begin
                    gap_cnt_next = gap_cnt_reg + 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase

        arb_busy_next = (state_next != IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg         <= IDLE;
            ptr_reg           <= IW'(NUM_REQ - 1);
            timer_reg         <= '0;
            gap_cnt_reg       <= '0;
            tx_p_data_reg     <= '0;
            tx_par_en_reg     <= 1'b0;
            tx_data_valid_reg <= 1'b0;
            grant_id_reg      <= '0;
            arb_busy_reg      <= 1'b0;
            ack_reg           <= '0;
            err_reg           <= '0;
        end else begin
            state_reg         <= state_next;
            ptr_reg           <= ptr_next;
            timer_reg         <= timer_next;
            gap_cnt_reg       <= gap_cnt_next;
            tx_p_data_reg     <= tx_p_data_next;
            tx_par_en_reg     <= tx_par_en_next;
            tx_data_valid_reg <= tx_data_valid_next;
            grant_id_reg      <= grant_id_next;
            arb_busy_reg      <= arb_busy_next;
            ack_reg           <= ack_next;
            err_reg           <= err_next;
        end
    end

    assign bus.tx_p_data     = tx_p_data_reg;
    assign bus.tx_par_en     = tx_par_en_reg;
    assign bus.tx_data_valid = tx_data_valid_reg;
    assign bus.grant_id      = grant_id_reg;
    assign bus.arb_busy      = arb_busy_reg;
    assign bus.ack           = ack_reg;
    assign bus.err           = err_reg;
endmodule
